axi4_burst_addr_gen: RTL and testbench
======================================

Name: axi4_burst_addr_gen

Overview:
- Per-beat address generator sitting directly downstream of the AXI4 slave write/read address channel stages.
- Accepts one captured burst descriptor (addr, id, len, size, burst) and emits one address per beat toward the memory backend, with last-beat and error flags.
- Supports FIXED, INCR and WRAP bursts per AXI4. Instantiated twice in the slave: once on the write path, once on the read path.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data bus width in bits; MAX_SIZE = log2(DATA_WIDTH/8).
- ID_WIDTH, 4, transaction ID width.
- LEN_WIDTH, 8, burst length field width (beats = len+1).
- SIZE_WIDTH, 3, burst size field width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  descriptor valid from address channel.
- cmd_ready  out  1  block can accept a descriptor.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_id  in  ID_WIDTH  transaction ID.
- cmd_len  in  LEN_WIDTH  beats minus one.
- cmd_size  in  SIZE_WIDTH  log2 bytes per beat.
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid  out  1  beat address valid.
- beat_ready  in  1  consumer accepts beat.
- beat_addr  out  ADDR_WIDTH  address of current beat.
- beat_id  out  ID_WIDTH  ID of current burst.
- beat_idx  out  LEN_WIDTH  beat number, 0-based.
- beat_last  out  1  current beat is final beat.
- beat_err  out  1  burst illegal; consumer returns SLVERR for every beat.
- busy  out  1  burst in progress.

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=1, beat_valid=0, beat_addr=0, beat_id=0, beat_idx=0, beat_last=0, beat_err=0, busy=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, register the descriptor, go to BURST.
  - BURST: cmd_ready=0, busy=1, beat_valid=1.
- Latency: descriptor accepted at edge N; first beat_valid=1 with beat_idx=0 from edge N+1.
- Handshake:
  - Beat transfers on beat_valid && beat_ready. Outputs are held stable while beat_valid && !beat_ready.
  - On transfer with beat_last=0: beat_idx+1, beat_addr = next address.
  - On transfer with beat_last=1: go to IDLE; beat_valid=0 and cmd_ready=1 next cycle (one-cycle bubble between bursts; no same-cycle re-accept).
- beat_last = (beat_idx == stored len). len=0 gives a single beat with beat_last=1.
- Address arithmetic (bytes = 1<<size):
  - FIXED: every beat = start addr.
  - INCR: beat 0 = start addr (unaligned allowed). Following beats = aligned(start, bytes) + idx*bytes. Wraps modulo 2^ADDR_WIDTH.
  - WRAP: total = bytes*(len+1); lower = addr & ~(total-1). next = addr+bytes; if next == lower+total, next = lower.
- Error detection, computed at accept and stored in beat_err for the whole burst:
  - size > MAX_SIZE.
  - burst==11.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with start addr not aligned to bytes.
  - INCR crossing a 4KB boundary: (addr[11:0] + bytes*(len+1) computed aligned) > 4096.
- Erroneous bursts still emit len+1 beats so the data channel stays in lockstep. Their addresses use FIXED behaviour (start addr) so no stray memory accesses occur.
- Simultaneous cmd_valid while in BURST: ignored (cmd_ready=0); the master holds it.
- Reset mid-burst: immediate return to reset values; the in-flight burst is discarded.
- Width rule: internal address sums computed at ADDR_WIDTH+1 bits for the 4KB check; the beat counter is LEN_WIDTH bits.

Test Plan:
- INCR aligned: addr=0x1000, len=3, size=2 -> beats 0x1000, 0x1004, 0x1008, 0x100C; beat_last only on idx 3; beat_err=0; first beat_valid one cycle after accept.
- WRAP: addr=0x0108, len=3, size=2 -> 0x0108, 0x010C, 0x0100, 0x0104; beat_last on 0x0104.
- FIXED with backpressure: addr=0x20, len=2, beat_ready low 3 cycles on beat 1 -> addr stays 0x20 with beat_idx=1 held stable; three total transfers.
- Errors: WRAP len=2 -> beat_err=1 on all 3 beats, addr constant. INCR addr=0x0FF8, len=3, size=2 (crosses 4KB) -> beat_err=1, 4 beats. size=3 with DATA_WIDTH=32 -> beat_err=1.
- Back-to-back plus reset: second cmd_valid held during a burst is not accepted until the cycle after the last beat. Asserting rst during beat 1 of len=7 -> all outputs return to reset values asynchronously; the next command starts at idx 0.

Source files
------------

// File: rtl/axi4_burst_addr_gen_if.sv
// Descriptor and beat channels of the AXI4 per-beat address generator.
// slave is the generator's view; master is the address-stage/consumer view.
interface axi4_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [SIZE_WIDTH-1:0] cmd_size;
    logic [1:0]            cmd_burst;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ID_WIDTH-1:0]   beat_id;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic                  beat_last;
    logic                  beat_err;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_err, busy
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_err, busy
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat AXI4 address generator: takes one FIXED/INCR/WRAP descriptor and emits
// one address per beat with last/error flags; illegal bursts replay the start address.
module axi4_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_burst_addr_gen_if.slave bus
);
    localparam int         MAX_SIZE    = $clog2(DATA_WIDTH / 8);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wrap_mask_q, wrap_mask_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;

    logic                  last;
    logic                  cmd_err;
    logic [ADDR_WIDTH-1:0] cmd_bytes, cmd_lo_mask;
    logic [ADDR_WIDTH:0]   span_4k;
    logic [ADDR_WIDTH-1:0] beat_bytes, incr_addr, wrap_lower, next_addr;

    // Descriptor legality, evaluated on the raw command so it can be latched at accept.
    always_comb begin
        cmd_bytes   = ADDR_WIDTH'(1) << bus.cmd_size;
        cmd_lo_mask = cmd_bytes - ADDR_WIDTH'(1);
        span_4k     = (ADDR_WIDTH+1)'(bus.cmd_addr[11:0] & ~cmd_lo_mask[11:0])
                    + (((ADDR_WIDTH+1)'(bus.cmd_len) + (ADDR_WIDTH+1)'(1)) << bus.cmd_size);
        cmd_err     = bus.cmd_size > SIZE_WIDTH'(MAX_SIZE);
        unique case (bus.cmd_burst)
            BURST_RSVD: cmd_err = 1'b1;
            BURST_WRAP: begin
                if (!(bus.cmd_len == LEN_WIDTH'(1) || bus.cmd_len == LEN_WIDTH'(3) ||
                      bus.cmd_len == LEN_WIDTH'(7) || bus.cmd_len == LEN_WIDTH'(15)))
                    cmd_err = 1'b1;
                if ((bus.cmd_addr & cmd_lo_mask) != '0)
                    cmd_err = 1'b1;
            end
            BURST_INCR: if (span_4k > (ADDR_WIDTH+1)'(4096)) cmd_err = 1'b1;
            default: ;
        endcase
    end

    // Address of the beat after the current one; erroneous and FIXED bursts hold.
    always_comb begin
        beat_bytes = ADDR_WIDTH'(1) << size_q;
        incr_addr  = addr_q + beat_bytes;
        wrap_lower = addr_q & ~wrap_mask_q;
        next_addr  = addr_q;
        if (!err_q) begin
            unique case (burst_q)
                BURST_INCR: next_addr = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
                BURST_WRAP: next_addr = (incr_addr == wrap_lower + wrap_mask_q + ADDR_WIDTH'(1))
                                        ? wrap_lower : incr_addr;
                default: ;
            endcase
        end
    end

    assign last = (idx_q == len_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wrap_mask_d = wrap_mask_q;
        id_d        = id_q;
        len_d       = len_q;
        idx_d       = idx_q;
        size_d      = size_q;
        burst_d     = burst_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = S_BURST;
                    addr_d      = bus.cmd_addr;
                    wrap_mask_d = ((ADDR_WIDTH'(bus.cmd_len) + ADDR_WIDTH'(1)) << bus.cmd_size)
                                - ADDR_WIDTH'(1);
                    id_d        = bus.cmd_id;
                    len_d       = bus.cmd_len;
                    idx_d       = '0;
                    size_d      = bus.cmd_size;
                    burst_d     = bus.cmd_burst;
                    err_d       = cmd_err;
                end
            end
            S_BURST: begin
                if (bus.beat_ready) begin
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_q + LEN_WIDTH'(1);
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wrap_mask_q <= '0;
            id_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wrap_mask_q <= wrap_mask_d;
            id_q        <= id_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.beat_valid = (state_q == S_BURST);
    assign bus.busy       = (state_q == S_BURST);
    assign bus.beat_last  = (state_q == S_BURST) && last;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_id    = id_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_err   = err_q;
endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen: directed bursts from the test plan plus
// randomized descriptors and backpressure, checked against an arithmetic beat model.
module tb_axi4_burst_addr_gen;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 8;
    localparam int SW = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [LW-1:0] len;
        logic [SW-1:0] size;
        logic [1:0]    burst;
    } desc_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    axi4_burst_addr_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW)) bus ();

    axi4_burst_addr_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Legality rules taken straight from the AXI4 burst constraints.
    function automatic bit model_err(input desc_t d);
        longint b   = longint'(1) << d.size;
        longint a   = longint'(d.addr);
        longint off;
        if (d.size > 2) return 1'b1;
        if (d.burst == 2'b11) return 1'b1;
        if (d.burst == 2'b10) begin
            if (!(d.len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
            if ((a % b) != 0) return 1'b1;
        end
        if (d.burst == 2'b01) begin
            off = (a & 64'hFFF) & ~(b - 1);
            if (off + b * (longint'(d.len) + 1) > 4096) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Address of beat i computed directly, not by stepping from the previous beat.
    function automatic logic [AW-1:0] model_addr(input desc_t d, input int i);
        longint a = longint'(d.addr);
        longint b = longint'(1) << d.size;
        longint total, lower;
        if (model_err(d) || d.burst == 2'b00) return d.addr;
        if (d.burst == 2'b01) begin
            if (i == 0) return d.addr;
            return AW'((a & ~(b - 1)) + longint'(i) * b);
        end
        total = b * (longint'(d.len) + 1);
        lower = a - (a % total);
        return AW'(lower + (a - lower + longint'(i) * b) % total);
    endfunction

    task automatic drive_cmd(input desc_t d);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = d.addr;
        bus.cmd_id    = d.id;
        bus.cmd_len   = d.len;
        bus.cmd_size  = d.size;
        bus.cmd_burst = d.burst;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, "_valid"},     64'(bus.beat_valid), 64'd0);
        check({tag, "_addr"},      64'(bus.beat_addr), 64'd0);
        check({tag, "_id"},        64'(bus.beat_id), 64'd0);
        check({tag, "_idx"},       64'(bus.beat_idx), 64'd0);
        check({tag, "_last"},      64'(bus.beat_last), 64'd0);
        check({tag, "_err"},       64'(bus.beat_err), 64'd0);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
    endtask

    // Entered and left just after a falling edge. Optionally holds the next
    // descriptor valid for the whole burst to prove it is not accepted early.
    task automatic run_burst(input desc_t d, input int stall_pct, input int stall_beat,
                             input int stall_n, input bit hold_next, input desc_t nxt);
        int k       = 0;
        int stalled = 0;
        int cycles  = 0;
        int nb      = int'(d.len) + 1;
        bit e       = model_err(d);
        drive_cmd(d);
        check("accept_ready", 64'(bus.cmd_ready), 64'd1);
        check("accept_valid", 64'(bus.beat_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        if (hold_next) drive_cmd(nxt);
        else bus.cmd_valid = 1'b0;
        while (k < nb && cycles < 4000) begin
            check("beat_valid", 64'(bus.beat_valid), 64'd1);
            check("beat_busy",  64'(bus.busy), 64'd1);
            check("beat_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            check("beat_addr",  64'(bus.beat_addr), 64'(model_addr(d, k)));
            check("beat_id",    64'(bus.beat_id), 64'(d.id));
            check("beat_idx",   64'(bus.beat_idx), 64'(k));
            check("beat_last",  64'(bus.beat_last), 64'(k == nb - 1));
            check("beat_err",   64'(bus.beat_err), 64'(e));
            if (k == stall_beat && stalled < stall_n) begin
                bus.beat_ready = 1'b0;
                stalled++;
            end else begin
                bus.beat_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            @(posedge clk);
            if (bus.beat_ready) k++;
            @(negedge clk);
            cycles++;
        end
        check("beat_count", 64'(k), 64'(nb));
        bus.beat_ready = 1'b0;
        check("end_valid", 64'(bus.beat_valid), 64'd0);
        check("end_ready", 64'(bus.cmd_ready), 64'd1);
        check("end_busy",  64'(bus.busy), 64'd0);
    endtask

    function automatic desc_t mk(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                                 input logic [LW-1:0] len, input logic [SW-1:0] size,
                                 input logic [1:0] burst);
        desc_t d;
        d.addr = addr; d.id = id; d.len = len; d.size = size; d.burst = burst;
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t  d;
        longint b;
        d.burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        d.size  = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(3, 7)) : SW'($urandom_range(0, 2));
        if (d.burst == 2'b10 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
                0: d.len = 8'd1;
                1: d.len = 8'd3;
                2: d.len = 8'd7;
                default: d.len = 8'd15;
            endcase
        end else if ($urandom_range(0, 9) == 0) begin
            d.len = LW'($urandom_range(0, 255));
        end else begin
            d.len = LW'($urandom_range(0, 15));
        end
        d.addr = $urandom;
        if ($urandom_range(0, 3) == 0)
            d.addr = (d.addr & 32'hFFFF_F000) | (32'h0000_0FC0 + 32'($urandom_range(0, 63)));
        b = longint'(1) << d.size;
        if (d.burst == 2'b10 && $urandom_range(0, 3) != 0)
            d.addr = d.addr & ~AW'(b - 1);
        d.id = IW'($urandom_range(0, 15));
        return d;
    endfunction

    desc_t rq[40];
    desc_t dummy;

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_id     = '0;
        bus.cmd_len    = '0;
        bus.cmd_size   = '0;
        bus.cmd_burst  = '0;
        bus.beat_ready = 1'b0;
        dummy          = mk(32'h0, 4'h0, 8'd0, 3'd0, 2'b00);
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");

        run_burst(mk(32'h0000_1000, 4'h5, 8'd3, 3'd2, 2'b01), 0, -1, 0, 1'b0, dummy);
        run_burst(mk(32'h0000_0108, 4'h6, 8'd3, 3'd2, 2'b10), 0, -1, 0, 1'b0, dummy);
        run_burst(mk(32'h0000_0020, 4'h7, 8'd2, 3'd2, 2'b00), 0, 1, 3, 1'b0, dummy);
        run_burst(mk(32'h0000_0100, 4'h8, 8'd2, 3'd2, 2'b10), 0, -1, 0, 1'b0, dummy);
        run_burst(mk(32'h0000_0FF8, 4'h9, 8'd3, 3'd2, 2'b01), 30, -1, 0, 1'b0, dummy);
        run_burst(mk(32'h0000_0000, 4'hA, 8'd1, 3'd3, 2'b01), 0, -1, 0, 1'b0, dummy);
        run_burst(mk(32'h0000_3000, 4'hB, 8'd1, 3'd2, 2'b01), 40, -1, 0, 1'b1,
                  mk(32'h0000_4000, 4'hC, 8'd2, 3'd1, 2'b01));
        run_burst(mk(32'h0000_4000, 4'hC, 8'd2, 3'd1, 2'b01), 0, -1, 0, 1'b0, dummy);

        // Reset in the middle of beat 1 of an 8-beat burst.
        drive_cmd(mk(32'h0000_2000, 4'hD, 8'd7, 3'd2, 2'b01));
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
        bus.beat_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.beat_ready = 1'b0;
        check("mid_idx", 64'(bus.beat_idx), 64'd1);
        check("mid_addr", 64'(bus.beat_addr), 64'h2004);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_burst(mk(32'h0000_5004, 4'hE, 8'd4, 3'd2, 2'b01), 20, -1, 0, 1'b0, dummy);

        foreach (rq[i]) rq[i] = rand_desc();
        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = (i < 39) && ($urandom_range(0, 1) == 1);
            run_burst(rq[i], int'($urandom_range(0, 60)), -1, 0, hold, (i < 39) ? rq[i+1] : dummy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
